imm_encoder: RTL and testbench
==============================

# imm_encoder

Packs decoded instruction fields and a 64-bit immediate back into a 32-bit RV64 instruction word. It is the inverse of the core's immediate sign-extension stage. It sits between the test/boot program generator and instruction memory. Every emitted word round-trips through the sign-extension stage to the original immediate. Out-of-range immediates are flagged and counted. The block has one registered stage with a valid/ready handshake and a skid buffer.

## Interface
Parameters:
- ERR_CNT_W, 16, width of saturating range-error counter

Ports:
- i_clk  in  1  clock, all state on rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_valid  in  1  upstream field bundle valid
- o_ready  out  1  block can accept a bundle this cycle (registered)
- i_opcode  in  7  opcode (opcodes package values)
- i_funct3  in  3  funct3
- i_funct7  in  7  funct7 (R-type, SLLI/SRAI upper bits)
- i_rd, i_rs1, i_rs2  in  5 each  register indices
- i_imm  in  64  immediate as the sign-extension stage would output it
- o_valid  out  1  o_instr valid
- i_ready  in  1  downstream accepts o_instr
- o_instr  out  32  encoded instruction
- o_range_err  out  1  o_instr immediate was truncated/illegal (qualified by o_valid)
- o_err_count  out  ERR_CNT_W  saturating count of accepted bundles with range_err

## Operation
- Accept: i_valid && o_ready. Emit: o_valid && i_ready.
- Common fields: rd→[11:7] (I, U, UJ, R); rs1→[19:15] and funct3→[14:12] (I, S, SB, R); rs2→[24:20] (S, SB, R); opcode→[6:0].
- IMM_ARITH (0010011):
  - funct3 F3_SLLI (001) or F3_SRAI (101): [31:25]=funct7, [24:20]=imm[4:0]. Legal range is 0..31.
  - Any other funct3: [31:20]=imm[11:0]. Legal range is -2048..2047.
- JALR (1100111): [31:20]=imm[11:0]. Legal range is signed 12-bit.
- LD (0000011): [31:20]=imm[11:0].
  - funct3 F3_LBU (100): legal range is 0..4095.
  - Otherwise: legal range is signed 12-bit.
- TYPE_S (0100011): [31:25]=imm[11:5], [11:7]=imm[4:0]. Legal range is signed 12-bit.
- TYPE_SB (1100011): imm is a halfword offset, with no shift here. [31]=imm[11], [7]=imm[10], [30:25]=imm[9:4], [11:8]=imm[3:0]. Legal range is signed 12-bit.
- TYPE_U (0110111): [31:12]=imm[31:12]. Legal only if imm[11:0]==0 and imm[63:32] is all copies of imm[31].
- TYPE_UJ (1101111): imm is a halfword offset. [31]=imm[19], [19:12]=imm[18:11], [20]=imm[10], [30:21]=imm[9:0]. Legal range is signed 20-bit.
- R-type (0110011): [31:25]=funct7. No immediate; never an error.
- Any other opcode: o_instr=32'h0 and range_err=1.
- On a range error the word is still emitted with the truncated field bits shown above.
- Error counter:
  - Increments when a bundle that raises range_err is accepted.
  - Saturates at all-ones.
- Buffering uses a main output register plus one skid register.
  - o_ready = !skid_full, registered.
  - When the main register is full, not being drained, and a bundle is accepted, the bundle goes to skid.
  - When main drains, skid moves to main in the same edge.
  - Order is always preserved.

## Timing
- Reset values, applied asynchronously: o_valid=0, o_instr=0, o_range_err=0, o_err_count=0, skid empty, o_ready=1.
- Latency: a bundle accepted at edge N is on o_instr/o_valid after edge N.
- Throughput: 1 word/cycle while i_ready=1.
- Backpressure:
  - o_valid and o_instr stay stable while i_ready=0.
  - At most 2 words are held.
  - o_ready falls the cycle after the skid fills. The bundle accepted in that cycle is held, never dropped.
- Simultaneous accept and emit with skid empty: main is replaced by the new bundle and o_valid stays 1.
- Simultaneous accept and emit with skid full cannot occur, because o_ready=0.
- Counter increment and saturation occur on the accept edge.
- Reset mid-stream discards both held words. o_valid=0 immediately, with no partial emission.

## Test plan
- addi: opcode 0010011, f3 000, rd 1, rs1 0, imm 64'hFFFF_FFFF_FFFF_FFFF → o_instr 32'hFFF00093 one cycle later, o_range_err 0.
- lui: opcode 0110111, rd 5, imm 64'h0000_0000_1234_5000 → 32'h123452B7, no error.
- beq: opcode 1100011, rs1 1, rs2 2, f3 000, imm -2 → 32'hFE208EE3.
- Range error: addi with imm 2048 → o_range_err 1, o_instr[31:20]=12'h800, o_err_count 1. Also drive 65536 errors and check o_err_count holds at 16'hFFFF.
- Backpressure: stream 4 bundles back-to-back with i_ready=0 for 3 cycles.
  - o_ready goes 0 after 2 words are held.
  - No word is lost or duplicated and order is preserved.
  - Random valid/ready round-trip through the sign-extension model matches the input.
- Reset with 2 words held → o_valid 0 and o_ready 1 immediately, o_err_count 0, and the next accepted bundle emerges after 1 cycle.

Source files
------------

// File: rtl/imm_encoder.sv
// imm_encoder: packs decoded fields and a 64-bit immediate into an RV64 instruction word behind a skid-buffered output stage
module imm_encoder #(
  parameter int ERR_CNT_W = 16
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [6:0]           i_opcode,
  input  logic [2:0]           i_funct3,
  input  logic [6:0]           i_funct7,
  input  logic [4:0]           i_rd,
  input  logic [4:0]           i_rs1,
  input  logic [4:0]           i_rs2,
  input  logic [63:0]          i_imm,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [31:0]          o_instr,
  output logic                 o_range_err,
  output logic [ERR_CNT_W-1:0] o_err_count
);
  localparam logic [6:0] OP_IMM_ARITH = 7'b0010011;
  localparam logic [6:0] OP_JALR      = 7'b1100111;
  localparam logic [6:0] OP_LD        = 7'b0000011;
  localparam logic [6:0] OP_S         = 7'b0100011;
  localparam logic [6:0] OP_SB        = 7'b1100011;
  localparam logic [6:0] OP_U         = 7'b0110111;
  localparam logic [6:0] OP_UJ        = 7'b1101111;
  localparam logic [6:0] OP_R         = 7'b0110011;
  localparam logic [2:0] F3_SLLI      = 3'b001;
  localparam logic [2:0] F3_SRAI      = 3'b101;
  localparam logic [2:0] F3_LBU       = 3'b100;
  logic [31:0]          w_instr;
  logic                 w_err;
  logic                 w_s12;
  logic                 w_s20;
  logic                 w_shift;
  logic                 w_accept;
  logic                 w_emit;
  logic                 r_valid;
  logic [31:0]          r_instr;
  logic                 r_err;
  logic                 r_skid_valid;
  logic [31:0]          r_skid_instr;
  logic                 r_skid_err;
  logic [ERR_CNT_W-1:0] r_err_count;
  assign w_s12    = i_imm[63:11] == {53{i_imm[11]}};
  assign w_s20    = i_imm[63:19] == {45{i_imm[19]}};
  assign w_shift  = i_funct3 == F3_SLLI || i_funct3 == F3_SRAI;
  assign w_accept = i_valid && o_ready;
  assign w_emit   = r_valid && i_ready;
  // Pack the bundle on the inputs and flag immediates that the field cannot hold
  always_comb begin
    w_instr = 32'h0;
    w_err   = 1'b0;
    case (i_opcode)
      OP_IMM_ARITH: begin
        w_instr = w_shift ? {i_funct7, i_imm[4:0], i_rs1, i_funct3, i_rd, i_opcode}
                          : {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
        w_err   = w_shift ? |i_imm[63:5] : !w_s12;
      end
      OP_JALR: begin
        w_instr = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
        w_err   = !w_s12;
      end
      OP_LD: begin
        w_instr = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
        w_err   = i_funct3 == F3_LBU ? |i_imm[63:12] : !w_s12;
      end
      OP_S: begin
        w_instr = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_opcode};
        w_err   = !w_s12;
      end
      OP_SB: begin
        w_instr = {i_imm[11], i_imm[9:4], i_rs2, i_rs1, i_funct3, i_imm[3:0], i_imm[10], i_opcode};
        w_err   = !w_s12;
      end
      OP_U: begin
        w_instr = {i_imm[31:12], i_rd, i_opcode};
        w_err   = |i_imm[11:0] || i_imm[63:32] != {32{i_imm[31]}};
      end
      OP_UJ: begin
        w_instr = {i_imm[19], i_imm[9:0], i_imm[10], i_imm[18:11], i_rd, i_opcode};
        w_err   = !w_s20;
      end
      OP_R: w_instr = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, i_opcode};
      default: w_err = 1'b1;
    endcase
  end
  // Main register refills from skid first, else from the input; a bundle arriving while main is stalled parks in skid
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_valid      <= 1'b0;
      r_instr      <= 32'h0;
      r_err        <= 1'b0;
      r_skid_valid <= 1'b0;
      r_skid_instr <= 32'h0;
      r_skid_err   <= 1'b0;
    end else if (!r_valid || w_emit) begin
      r_valid <= r_skid_valid || w_accept;
      if (r_skid_valid) begin
        r_instr      <= r_skid_instr;
        r_err        <= r_skid_err;
        r_skid_valid <= 1'b0;
      end else if (w_accept) begin
        r_instr <= w_instr;
        r_err   <= w_err;
      end
    end else if (w_accept) begin
      r_skid_valid <= 1'b1;
      r_skid_instr <= w_instr;
      r_skid_err   <= w_err;
    end
  end
  // Saturating count of accepted bundles whose immediate did not fit
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_err_count <= '0;
    else if (w_accept && w_err && !(&r_err_count)) r_err_count <= r_err_count + ERR_CNT_W'(1);
  end
  assign o_ready     = !r_skid_valid;
  assign o_valid     = r_valid;
  assign o_instr     = r_instr;
  assign o_range_err = r_err;
  assign o_err_count = r_err_count;
endmodule

// File: tb/tb_imm_encoder.sv
// tb_imm_encoder: directed vector table plus streaming, backpressure and reset sequences for imm_encoder
module tb_imm_encoder;
  typedef struct packed {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [63:0] imm;
  } bundle_t;
  typedef struct packed {
    bundle_t     b;
    logic [31:0] instr;
    logic        err;
  } vec_t;
  localparam int NV = 22;
  logic        clk;
  logic        i_reset;
  logic        i_valid;
  logic        o_ready;
  logic [6:0]  i_opcode;
  logic [2:0]  i_funct3;
  logic [6:0]  i_funct7;
  logic [4:0]  i_rd;
  logic [4:0]  i_rs1;
  logic [4:0]  i_rs2;
  logic [63:0] i_imm;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_instr;
  logic        o_range_err;
  logic [15:0] o_err_count;
  int          errors;
  int          checks;
  int          n_emit;
  int          exp_cnt;
  vec_t        tv [NV];
  bundle_t     q [$];
  bundle_t     cur;
  logic        pv_hold;
  logic [31:0] p_instr;
  logic        v;
  logic        r;
  logic        acc;
  imm_encoder #(.ERR_CNT_W(16)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
    .i_opcode(i_opcode), .i_funct3(i_funct3), .i_funct7(i_funct7),
    .i_rd(i_rd), .i_rs1(i_rs1), .i_rs2(i_rs2), .i_imm(i_imm),
    .o_valid(o_valid), .i_ready(i_ready), .o_instr(o_instr),
    .o_range_err(o_range_err), .o_err_count(o_err_count)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic vec_t mk(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                              input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [63:0] imm, input logic [31:0] instr, input logic err);
    mk = {op, f3, f7, rd, rs1, rs2, imm, instr, err};
  endfunction
  function automatic logic [63:0] sext_imm(input logic [31:0] w);
    case (w[6:0])
      7'h13:   sext_imm = (w[14:12] == 3'b001 || w[14:12] == 3'b101) ? {59'd0, w[24:20]} : {{52{w[31]}}, w[31:20]};
      7'h67:   sext_imm = {{52{w[31]}}, w[31:20]};
      7'h03:   sext_imm = w[14:12] == 3'b100 ? {52'd0, w[31:20]} : {{52{w[31]}}, w[31:20]};
      7'h23:   sext_imm = {{52{w[31]}}, w[31:25], w[11:7]};
      7'h63:   sext_imm = {{52{w[31]}}, w[31], w[7], w[30:25], w[11:8]};
      7'h37:   sext_imm = {{32{w[31]}}, w[31:12], 12'd0};
      7'h6F:   sext_imm = {{44{w[31]}}, w[31], w[19:12], w[20], w[30:21]};
      default: sext_imm = 64'd0;
    endcase
  endfunction
  function automatic bundle_t rand_bundle();
    bundle_t     b;
    logic [31:0] x;
    x     = $urandom;
    b.rd  = 5'($urandom_range(0, 31));
    b.rs1 = 5'($urandom_range(0, 31));
    b.rs2 = 5'($urandom_range(0, 31));
    b.f3  = 3'd0;
    b.f7  = 7'd0;
    case ($urandom_range(0, 8))
      0: begin b.op = 7'h13; b.imm = {{52{x[11]}}, x[11:0]}; end
      1: begin b.op = 7'h13; b.f3 = 3'b001; b.imm = {59'd0, x[4:0]}; end
      2: begin b.op = 7'h67; b.imm = {{52{x[11]}}, x[11:0]}; end
      3: begin b.op = 7'h03; b.f3 = 3'b100; b.imm = {52'd0, x[11:0]}; end
      4: begin b.op = 7'h23; b.f3 = 3'b011; b.imm = {{52{x[11]}}, x[11:0]}; end
      5: begin b.op = 7'h63; b.f3 = 3'b001; b.imm = {{52{x[11]}}, x[11:0]}; end
      6: begin b.op = 7'h37; b.imm = {{32{x[31]}}, x[31:12], 12'd0}; end
      7: begin b.op = 7'h6F; b.imm = {{44{x[19]}}, x[19:0]}; end
      default: begin b.op = 7'h33; b.f7 = 7'h20; b.imm = 64'd0; end
    endcase
    return b;
  endfunction
  task automatic drive(input bundle_t b);
    i_opcode = b.op;
    i_funct3 = b.f3;
    i_funct7 = b.f7;
    i_rd     = b.rd;
    i_rs1    = b.rs1;
    i_rs2    = b.rs2;
    i_imm    = b.imm;
  endtask
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask
  task automatic step(input logic sv, input logic sr, input bundle_t b, output logic sacc);
    bundle_t     e;
    logic [63:0] got;
    logic        emt;
    drive(b);
    i_valid = sv;
    i_ready = sr;
    if (pv_hold) begin
      checks++;
      if (!o_valid || o_instr !== p_instr) begin
        errors++;
        $display("FAIL hold_stable: got valid %b instr %h, want valid 1 instr %h", o_valid, o_instr, p_instr);
      end
    end
    sacc = sv && o_ready;
    emt  = o_valid && sr;
    if (emt) begin
      checks++;
      n_emit++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL stream_extra: got word %h with nothing pending", o_instr);
      end else begin
        e   = q.pop_front();
        got = sext_imm(o_instr);
        if (o_instr[6:0] !== e.op || got !== e.imm || o_range_err !== 1'b0 ||
            (e.op != 7'h23 && e.op != 7'h63 && o_instr[11:7] !== e.rd)) begin
          errors++;
          $display("FAIL stream_word: got instr %h imm %h err %b, want op %h imm %h rd %0d",
                   o_instr, got, o_range_err, e.op, e.imm, e.rd);
        end
      end
    end
    if (sacc) q.push_back(b);
    pv_hold = o_valid && !sr;
    p_instr = o_instr;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic do_reset();
    i_valid = 1'b0;
    i_reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_instr", 64'(o_instr), 64'd0);
    chk("rst_err", 64'(o_range_err), 64'd0);
    chk("rst_count", 64'(o_err_count), 64'd0);
    chk("rst_ready", 64'(o_ready), 64'd1);
    i_reset = 1'b0;
    pv_hold = 1'b0;
    q.delete();
  endtask
  initial begin
    errors  = 0;
    checks  = 0;
    n_emit  = 0;
    exp_cnt = 0;
    pv_hold = 1'b0;
    p_instr = 32'h0;
    i_valid = 1'b0;
    i_ready = 1'b1;
    i_reset = 1'b1;
    drive('0);
    tv[0]  = mk(7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFF00093, 1'b0);
    tv[1]  = mk(7'h37, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 64'h0000_0000_1234_5000, 32'h123452B7, 1'b0);
    tv[2]  = mk(7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 64'hFFFF_FFFF_FFFF_FFFE, 32'hFE208EE3, 1'b0);
    tv[3]  = mk(7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 64'd2048, 32'h80000093, 1'b1);
    tv[4]  = mk(7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 64'hFFFF_FFFF_FFFF_F800, 32'h80000093, 1'b0);
    tv[5]  = mk(7'h13, 3'd1, 7'h00, 5'd1, 5'd2, 5'd0, 64'd3, 32'h00311093, 1'b0);
    tv[6]  = mk(7'h13, 3'd5, 7'h20, 5'd1, 5'd2, 5'd0, 64'd32, 32'h40015093, 1'b1);
    tv[7]  = mk(7'h67, 3'd0, 7'h00, 5'd1, 5'd5, 5'd0, 64'd2047, 32'h7FF280E7, 1'b0);
    tv[8]  = mk(7'h03, 3'd4, 7'h00, 5'd3, 5'd4, 5'd0, 64'd4095, 32'hFFF24183, 1'b0);
    tv[9]  = mk(7'h03, 3'd0, 7'h00, 5'd3, 5'd4, 5'd0, 64'd4095, 32'hFFF20183, 1'b1);
    tv[10] = mk(7'h23, 3'd2, 7'h00, 5'd0, 5'd2, 5'd3, 64'hFFFF_FFFF_FFFF_FFFC, 32'hFE312E23, 1'b0);
    tv[11] = mk(7'h37, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 64'h0000_0000_1234_5001, 32'h123452B7, 1'b1);
    tv[12] = mk(7'h37, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 64'hFFFF_FFFF_8000_0000, 32'h800000B7, 1'b0);
    tv[13] = mk(7'h37, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 64'h0000_0000_8000_0000, 32'h800000B7, 1'b1);
    tv[14] = mk(7'h6F, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 64'd2048, 32'h000010EF, 1'b0);
    tv[15] = mk(7'h6F, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFFF0EF, 1'b0);
    tv[16] = mk(7'h6F, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 64'h0000_0000_0008_0000, 32'h800000EF, 1'b1);
    tv[17] = mk(7'h33, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 64'd0, 32'h002081B3, 1'b0);
    tv[18] = mk(7'h33, 3'd0, 7'h20, 5'd3, 5'd1, 5'd2, 64'd0, 32'h402081B3, 1'b0);
    tv[19] = mk(7'h7F, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 64'd0, 32'h00000000, 1'b1);
    tv[20] = mk(7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 64'd2048, 32'h80208063, 1'b1);
    tv[21] = mk(7'h03, 3'd4, 7'h00, 5'd3, 5'd4, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFF24183, 1'b1);
    #2;
    chk("por_valid", 64'(o_valid), 64'd0);
    chk("por_ready", 64'(o_ready), 64'd1);
    @(negedge clk);
    do_reset();
    for (int k = 0; k < NV; k++) begin
      drive(tv[k].b);
      i_valid = 1'b1;
      i_ready = 1'b1;
      @(posedge clk);
      #1;
      i_valid = 1'b0;
      exp_cnt += int'(tv[k].err);
      chk($sformatf("vec%0d_valid", k), 64'(o_valid), 64'd1);
      chk($sformatf("vec%0d_instr", k), 64'(o_instr), 64'(tv[k].instr));
      chk($sformatf("vec%0d_err", k), 64'(o_range_err), 64'(tv[k].err));
      chk($sformatf("vec%0d_count", k), 64'(o_err_count), 64'(exp_cnt));
    end
    @(negedge clk);
    drive(tv[19].b);
    i_valid = 1'b1;
    i_ready = 1'b1;
    repeat (65536) @(posedge clk);
    #1;
    chk("sat_count", 64'(o_err_count), 64'hFFFF);
    @(posedge clk);
    #1;
    chk("sat_hold", 64'(o_err_count), 64'hFFFF);
    chk("sat_err", 64'(o_range_err), 64'd1);
    @(negedge clk);
    do_reset();
    n_emit = 0;
    step(1'b1, 1'b0, mk(7'h33, 3'd0, 7'h00, 5'd10, 5'd1, 5'd2, 64'd0, 32'h0, 1'b0).b, acc);
    step(1'b1, 1'b0, mk(7'h33, 3'd0, 7'h00, 5'd11, 5'd1, 5'd2, 64'd0, 32'h0, 1'b0).b, acc);
    chk("bp_ready_low", 64'(o_ready), 64'd0);
    step(1'b1, 1'b0, mk(7'h33, 3'd0, 7'h00, 5'd12, 5'd1, 5'd2, 64'd0, 32'h0, 1'b0).b, acc);
    chk("bp_third_held", 64'(acc), 64'd0);
    step(1'b1, 1'b1, mk(7'h33, 3'd0, 7'h00, 5'd12, 5'd1, 5'd2, 64'd0, 32'h0, 1'b0).b, acc);
    chk("bp_ready_back", 64'(o_ready), 64'd1);
    step(1'b1, 1'b1, mk(7'h33, 3'd0, 7'h00, 5'd12, 5'd1, 5'd2, 64'd0, 32'h0, 1'b0).b, acc);
    step(1'b1, 1'b1, mk(7'h33, 3'd0, 7'h00, 5'd13, 5'd1, 5'd2, 64'd0, 32'h0, 1'b0).b, acc);
    for (int k = 0; k < 10 && (q.size() != 0 || o_valid); k++) step(1'b0, 1'b1, '0, acc);
    chk("bp_emitted", 64'(n_emit), 64'd4);
    chk("bp_pending", 64'(q.size()), 64'd0);
    cur = rand_bundle();
    for (int k = 0; k < 400; k++) begin
      v = $urandom_range(0, 3) != 0;
      r = $urandom_range(0, 2) != 0;
      step(v, r, cur, acc);
      if (acc) cur = rand_bundle();
    end
    for (int k = 0; k < 10 && (q.size() != 0 || o_valid); k++) step(1'b0, 1'b1, '0, acc);
    chk("rand_pending", 64'(q.size()), 64'd0);
    chk("rand_drained", 64'(o_valid), 64'd0);
    step(1'b1, 1'b0, tv[19].b, acc);
    step(1'b1, 1'b0, tv[19].b, acc);
    chk("held_ready", 64'(o_ready), 64'd0);
    chk("held_count", 64'(o_err_count), 64'd2);
    i_valid = 1'b0;
    #2 i_reset = 1'b1;
    #1;
    chk("midrst_valid", 64'(o_valid), 64'd0);
    chk("midrst_ready", 64'(o_ready), 64'd1);
    chk("midrst_count", 64'(o_err_count), 64'd0);
    #1 i_reset = 1'b0;
    pv_hold = 1'b0;
    q.delete();
    @(negedge clk);
    chk("postrst_idle", 64'(o_valid), 64'd0);
    drive(tv[0].b);
    i_valid = 1'b1;
    i_ready = 1'b1;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    chk("postrst_valid", 64'(o_valid), 64'd1);
    chk("postrst_instr", 64'(o_instr), 64'h0000_0000_FFF0_0093);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
